// File: rtl/cheri_btb.sv
// Branch target buffer holding full-PCC targets for mispredicted
// register-indirect jumps; one registered lookup per cycle.
package config_pkg;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned PCLEN;
    bit          RVC;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    VLEN:  32,
    PCLEN: 64,
    RVC:   1'b1
  };

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [63:0] target_address;
    logic        is_mispredict;
    logic        is_taken;
    cf_t         cf_type;
  } bp_resolve_t;

endpackage

module cheri_btb #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg =
    config_pkg::cva6_cfg_empty,
  parameter type bp_resolve_t =
    config_pkg::bp_resolve_t,
  parameter int unsigned NR_ENTRIES = 32,
  parameter int unsigned TAG_BITS   = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_bp_i,
  input  logic        debug_mode_i,
  input  bp_resolve_t resolved_branch_i,
  input  logic        lookup_valid_i,
  input  logic [CVA6Cfg.VLEN-1:0] lookup_pc_i,
  input  logic [CVA6Cfg.PCLEN-CVA6Cfg.VLEN-1:0]
                      pcc_meta_i,
  output logic        pred_valid_o,
  output logic [CVA6Cfg.PCLEN-1:0] pred_target_o,
  output logic        busy_o
);

  localparam int VLEN  = int'(CVA6Cfg.VLEN);
  localparam int PCLEN = int'(CVA6Cfg.PCLEN);
  localparam int LSB   = CVA6Cfg.RVC ? 1 : 2;
  localparam int IDX   = $clog2(NR_ENTRIES);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [IDX-1:0]        cnt_q, cnt_d;
  logic [NR_ENTRIES-1:0] valid_q;
  logic [TAG_BITS-1:0]   tag_q [NR_ENTRIES];
  logic [PCLEN-1:0]      tgt_q [NR_ENTRIES];

  logic                  busy_q;
  logic                  pvld_q, pvld_d;
  logic [PCLEN-1:0]      ptgt_q, ptgt_d;

  logic                  clr;
  logic                  upd;
  logic [IDX-1:0]        widx;
  logic [TAG_BITS-1:0]   wtag;
  logic [IDX-1:0]        lidx;
  logic [TAG_BITS-1:0]   ltag;
  logic                  hit;

  assign widx = resolved_branch_i.pc[LSB+:IDX];
  assign wtag =
    resolved_branch_i.pc[LSB+IDX+:TAG_BITS];
  assign lidx = lookup_pc_i[LSB+:IDX];
  assign ltag = lookup_pc_i[LSB+IDX+:TAG_BITS];

  // a flush in the same cycle wins over the update
  assign upd = (state_q == IDLE)
             && !flush_bp_i
             && !debug_mode_i
             && resolved_branch_i.valid
             && resolved_branch_i.is_mispredict
             && (resolved_branch_i.cf_type
                 == config_pkg::JumpR);

  // reads see pre-write, pre-flush contents
  assign hit = lookup_valid_i
             && (state_q == IDLE)
             && valid_q[lidx]
             && (tag_q[lidx] == ltag)
             && (tgt_q[lidx][PCLEN-1:VLEN]
                 == pcc_meta_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_bp_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        clr   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (flush_bp_i) begin
          cnt_d = '0;
        end else if (cnt_q ==
                     IDX'(NR_ENTRIES-1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pvld_d = hit;
    ptgt_d = ptgt_q;
    if (hit) begin
      ptgt_d = tgt_q[lidx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= '0;
      pvld_q  <= 1'b0;
      ptgt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == FLUSH);
      pvld_q  <= pvld_d;
      ptgt_q  <= ptgt_d;
      if (clr) begin
        valid_q[cnt_q] <= 1'b0;
      end
      if (upd) begin
        valid_q[widx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (upd) begin
      tag_q[widx] <= wtag;
      tgt_q[widx] <=
        resolved_branch_i.target_address;
    end
  end

  assign pred_valid_o  = pvld_q;
  assign pred_target_o = ptgt_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_cheri_btb.sv
// Scoreboard bench for cheri_btb: lookups push expectations,
// a monitor pops and compares the registered prediction.
module tb_cheri_btb;
  import config_pkg::*;

  typedef struct {
    logic        v;
    logic [63:0] t;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dbg;
  bp_resolve_t rb;
  logic        lv;
  logic [31:0] lpc;
  logic [31:0] meta;
  logic        pv;
  logic [63:0] pt;
  logic        busy;

  exp_t exp_q[$];
  int   passed;
  int   total;

  localparam logic [31:0] M  = 32'hA5A5_0001;
  localparam logic [31:0] M2 = 32'h5A5A_0002;
  localparam logic [31:0] P1 = 32'h8000_1000;
  localparam logic [31:0] P2 = 32'h8000_1004;
  localparam logic [31:0] P3 = 32'h8000_1008;
  localparam logic [31:0] P4 = 32'h8000_100C;
  localparam logic [63:0] T1 = {M, 32'h8000_2000};
  localparam logic [63:0] T2 = {M, 32'h8000_3000};
  localparam logic [63:0] T3 = {M, 32'h8000_4000};

  cheri_btb dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_bp_i        (flush),
    .debug_mode_i      (dbg),
    .resolved_branch_i (rb),
    .lookup_valid_i    (lv),
    .lookup_pc_i       (lpc),
    .pcc_meta_i        (meta),
    .pred_valid_o      (pv),
    .pred_target_o     (pt),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h",
                  nm, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    dbg   = 1'b0;
    rb    = '0;
    lv    = 1'b0;
    lpc   = '0;
    meta  = '0;
  endtask

  task automatic look(input string nm,
                      input logic [31:0] pc,
                      input logic [31:0] m,
                      input logic v,
                      input logic [63:0] t);
    exp_t e;
    lv   = 1'b1;
    lpc  = pc;
    meta = m;
    e.v = v;
    e.t = t;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic [63:0] t,
                     input cf_t cf,
                     input logic d);
    rb.valid          = 1'b1;
    rb.pc             = pc;
    rb.target_address = t;
    rb.is_mispredict  = 1'b1;
    rb.is_taken       = 1'b1;
    rb.cf_type        = cf;
    dbg               = d;
  endtask

  // monitor: a lookup sampled at an edge is reported just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (lv === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pred: got %b want none",
                   pv);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_v"}, 64'(pv), 64'(e.v));
          chk({e.name, "_t"}, pt, e.t);
        end
      end
    end
  end

  initial begin
    int n;
    passed = 0;
    total  = 0;
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pv", 64'(pv), 64'd0);
    chk("rst_pt", pt, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    look("empty", P1, M, 1'b0, 64'd0);
    tick(); idle();

    upd(P1, T1, JumpR, 1'b0);
    tick(); idle();
    look("hit1", P1, M, 1'b1, T1);
    tick(); idle();
    look("meta_mis", P1, M2, 1'b0, T1);
    tick(); idle();
    look("meta_ok", P1, M, 1'b1, T1);
    tick(); idle();

    upd(P2, T2, JumpR, 1'b0);
    look("rd_first", P2, M, 1'b0, T1);
    tick(); idle();
    look("after_wr", P2, M, 1'b1, T2);
    tick(); idle();

    upd(P3, T3, JumpR, 1'b1);
    tick(); idle();
    look("dbg_upd", P3, M, 1'b0, T2);
    tick(); idle();
    upd(P4, T3, Return, 1'b0);
    tick(); idle();
    look("ret_upd", P4, M, 1'b0, T2);
    tick(); idle();

    // flush with a same-cycle lookup of pre-flush state
    flush = 1'b1;
    look("flush_cyc", P1, M, 1'b1, T1);
    tick(); idle();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      idle();
      if (n == 1) look("sweep_lk", P2, M, 1'b0, T1);
      if (n == 10) flush = 1'b1;
      if (n == 40) upd(P3, T3, JumpR, 1'b0);
      tick();
    end
    idle();
    chk("busy_len", 64'(n), 64'd42);

    look("post_p1", P1, M, 1'b0, T1);
    tick(); idle();
    look("post_p3", P3, M, 1'b0, T1);
    tick(); idle();
    upd(P1, T3, JumpR, 1'b0);
    tick(); idle();
    look("refill", P1, M, 1'b1, T3);
    tick(); idle();
    tick(); tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
